// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: start request, operands and the
// busy/done/result return path.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple chain
// of full-adder cells, carry held in a register between steps.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] digit_sum;
  logic [WIDTH-1:0] shifted;
  logic             last_step;

  assign chain[0] = carry_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_cell
      assign digit_sum[gi] = opa_reg[gi] ^ opb_reg[gi] ^ chain[gi];
      assign chain[gi+1]   = (opa_reg[gi] & opb_reg[gi]) |
                             (opb_reg[gi] & chain[gi])   |
                             (opa_reg[gi] & chain[gi]);
    end
  endgenerate

  // Result fills from the top so the first (least significant) digit ends up at bit 0.
  assign shifted   = (acc_reg >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
  assign last_step = (cnt_reg == CW'(STEPS - 1));

  always_comb begin
    state_next = state_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    acc_next   = acc_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          // Subtract as A + ~B + 1; the borrow-in cancels the +1.
          opa_next   = bus.a;
          opb_next   = bus.b ^ {WIDTH{bus.sub}};
          carry_next = bus.cin ^ bus.sub;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next   = shifted;
        opa_next   = opa_reg >> DIGIT;
        opb_next   = opb_reg >> DIGIT;
        carry_next = chain[DIGIT];
        cnt_next   = cnt_reg + CW'(1);
        if (last_step) begin
          sum_next   = shifted;
          cout_next  = chain[DIGIT];
          ovf_next   = chain[DIGIT-1] ^ chain[DIGIT];
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      opa_reg   <= '0;
      opb_reg   <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      acc_reg   <= acc_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/1-digit and a 16-bit/4-digit instance,
// table vectors, control corner cases and a random sweep against a model.
module tb_serial_adder;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  serial_adder_if #(.WIDTH(8))  i8 ();
  serial_adder_if #(.WIDTH(16)) i16 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (i8.slave)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (i16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          cin;
    bit          sub;
    logic [15:0] s;
    bit          co;
    bit          ov;
  } vec_t;

  vec_t        vecs[7];
  logic [17:0] prev8;
  logic [17:0] prev16;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input int sel, input bit st, input logic [15:0] a, input logic [15:0] b,
                       input bit cin, input bit sub);
    if (sel == 0) begin
      i8.start = st; i8.a = a[7:0]; i8.b = b[7:0]; i8.cin = cin; i8.sub = sub;
    end else begin
      i16.start = st; i16.a = a; i16.b = b; i16.cin = cin; i16.sub = sub;
    end
  endtask

  function automatic bit get_busy(input int sel);
    return (sel == 0) ? i8.busy : i16.busy;
  endfunction

  function automatic bit get_done(input int sel);
    return (sel == 0) ? i8.done : i16.done;
  endfunction

  function automatic logic [17:0] get_res(input int sel);
    if (sel == 0) return {i8.cout, i8.ovf, 8'h00, i8.sum};
    return {i16.cout, i16.ovf, i16.sum};
  endfunction

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic logic [17:0] model(input int w, input longint a, input longint b,
                                        input bit cin, input bit sub);
    longint half = longint'(1) << (w - 1);
    longint full = longint'(1) << w;
    longint sa   = (a >= half) ? a - full : a;
    longint sb   = (b >= half) ? b - full : b;
    longint u, sr;
    bit     co, ov;
    if (!sub) begin
      u  = a + b + longint'(cin);
      co = (u >= full);
      sr = sa + sb + longint'(cin);
    end else begin
      u  = a - b - longint'(cin);
      co = (a >= b + longint'(cin));
      sr = sa - sb - longint'(cin);
    end
    ov = (sr < -half) || (sr > half - 1);
    u  = u & (full - 1);
    return {co, ov, u[15:0]};
  endfunction

  task automatic run_op(input int sel, input string name, input logic [15:0] a, input logic [15:0] b,
                        input bit cin, input bit sub, input logic [17:0] exp);
    int          n;
    int          n_busy;
    int          steps;
    logic [17:0] prev;
    steps = (sel == 0) ? 8 : 4;
    prev  = (sel == 0) ? prev8 : prev16;
    @(negedge clk);
    drive(sel, 1'b1, a, b, cin, sub);
    @(negedge clk);
    drive(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    n = 0;
    n_busy = 0;
    while (!get_done(sel) && n < 40) begin
      if (get_busy(sel)) n_busy++;
      if (n == 0) check({name, " hold"}, longint'(get_res(sel)), longint'(prev));
      @(negedge clk);
      n++;
    end
    check({name, " done_seen"}, longint'(get_done(sel)), 1);
    check({name, " busy_cycles"}, n_busy, steps);
    check({name, " busy_in_done"}, longint'(get_busy(sel)), 0);
    check({name, " result"}, longint'(get_res(sel)), longint'(exp));
    @(negedge clk);
    check({name, " done_pulse"}, longint'(get_done(sel)), 0);
    if (sel == 0) prev8 = exp;
    else prev16 = exp;
    $display("op %s sel=%0d a=%h b=%h cin=%0d sub=%0d -> res=%h exp=%h",
             name, sel, a, b, cin, sub, get_res(sel), exp);
  endtask

  initial begin
    int          n;
    int          dones;
    logic [15:0] ra, rb;
    bit          rc, rs;

    n_pass  = 0;
    n_total = 0;
    prev8   = '0;
    prev16  = '0;
    vecs[0] = '{a: 16'h7F, b: 16'h01, cin: 0, sub: 0, s: 16'h80, co: 0, ov: 1};
    vecs[1] = '{a: 16'hFF, b: 16'h01, cin: 1, sub: 0, s: 16'h01, co: 1, ov: 0};
    vecs[2] = '{a: 16'h05, b: 16'h07, cin: 0, sub: 1, s: 16'hFE, co: 0, ov: 0};
    vecs[3] = '{a: 16'h80, b: 16'h01, cin: 0, sub: 1, s: 16'h7F, co: 1, ov: 1};
    vecs[4] = '{a: 16'h80, b: 16'h80, cin: 0, sub: 0, s: 16'h00, co: 1, ov: 1};
    vecs[5] = '{a: 16'h00, b: 16'h00, cin: 1, sub: 1, s: 16'hFF, co: 0, ov: 0};
    vecs[6] = '{a: 16'h00, b: 16'h00, cin: 0, sub: 0, s: 16'h00, co: 0, ov: 0};

    rst = 1'b1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset8", longint'({i8.busy, i8.done, get_res(0)}), 0);
    check("reset16", longint'({i16.busy, i16.done, get_res(1)}), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(0, $sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             {vecs[i].co, vecs[i].ov, vecs[i].s});

    run_op(1, "w16_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});

    // Start pulses during RUN and DONE must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 16'h12, 16'h34, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    dones = 0;
    n = 0;
    while (n < 20) begin
      if (i8.done) dones++;
      if (n == 3 || i8.done) drive(0, 1'b1, 16'hAA, 16'hBB, 1'b1, 1'b1);
      else drive(0, 1'b0, 16'hAA, 16'hBB, 1'b1, 1'b1);
      @(negedge clk);
      n++;
    end
    check("abuse_one_done", dones, 1);
    check("abuse_idle", longint'(i8.busy), 0);
    check("abuse_result", longint'(get_res(0)), longint'({1'b0, 1'b0, 16'h0046}));
    $display("op abuse dones=%0d res=%h", dones, get_res(0));

    // Reset in RUN step 3 discards the operation and clears outputs.
    @(negedge clk);
    drive(0, 1'b1, 16'hFF, 16'hFF, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_mid_busy", longint'(i8.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_outputs", longint'({i8.busy, i8.done, get_res(0)}), 0);
    dones = 0;
    repeat (12) begin
      if (i8.done) dones++;
      @(negedge clk);
    end
    check("rst_no_done", dones, 0);
    $display("op reset_mid_run dones=%0d res=%h", dones, get_res(0));
    prev8  = '0;
    prev16 = '0;
    run_op(0, "after_rst", 16'h3C, 16'h0F, 1'b0, 1'b0, {1'b0, 1'b0, 16'h004B});

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_op(0, $sformatf("rnd8_%0d", i), ra, rb, rc, rs, model(8, longint'(ra), longint'(rb), rc, rs));
    end
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_op(1, $sformatf("rnd16_%0d", i), ra, rb, rc, rs, model(16, longint'(ra), longint'(rb), rc, rs));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor that processes DIGIT bits per clock through a chain of DIGIT full-adder cells, with carry held in a register between cycles.
- Successor to the single-bit combinational full adder cell. Gives WIDTH-bit add and subtract with carry-in, carry-out and signed overflow at low area.
- Controlled by a start/busy/done handshake. Used wherever arithmetic latency is acceptable and area matters.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥ 2.
- DIGIT, 1, bits processed per clock. Must divide WIDTH exactly. Elaboration fails otherwise.
- STEPS (localparam), WIDTH/DIGIT, number of RUN cycles.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- a  in  WIDTH  operand A. Captured on start.
- b  in  WIDTH  operand B. Captured on start.
- cin  in  1  carry-in for add; borrow-in for subtract. Captured on start.
- sub  in  1  0 = A+B+cin; 1 = A−B−cin. Captured on start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result outputs updated in the same cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out. In subtract mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset: rst=1 at a clock edge has priority over all other activity and takes effect in every state, including mid-RUN.
  - Next state is IDLE.
  - busy, done, sum, cout, ovf and all internal registers go to 0.
  - Any operation in flight is discarded; no done is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures the operands: opA = a; opB = b XOR {WIDTH{sub}}.
  - Initial carry: carry = cin when sub=0; carry = ~cin when sub=1.
  - Step counter cleared to 0; next state RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each cycle, the low DIGIT bits of opA, opB and the carry register feed a ripple chain of DIGIT full-adder cells: s = x^y^c, co = xy|yc|xc.
  - The DIGIT sum bits shift into the top of the result shift register (LSB-first, shift right by DIGIT).
  - opA and opB shift right by DIGIT. Carry register takes the chain carry-out.
  - The step counter increments; it is ceil(log2(STEPS+1)) bits wide.
  - On the last step (counter == STEPS−1):
    - Record the carry into the MSB cell as cmsb.
    - Next state DONE.
    - Registered outputs load: sum = final shift register contents; cout = final carry; ovf = cmsb XOR final carry.
- DONE:
  - done=1 for exactly this one cycle; next state IDLE unconditionally.
- Handshake:
  - busy=1 exactly while in RUN.
  - start is ignored in RUN and DONE. Back-to-back operations therefore have a minimum spacing of STEPS+2 cycles.
  - Latency: start sampled at edge k → done high in the cycle after edge k+STEPS.
  - Operand inputs may change freely after the capture edge without affecting the result.
- Output stability: sum, cout and ovf change only at the DONE-entry edge or on reset. They hold the previous result throughout IDLE and RUN.
- Boundary cases:
  - DIGIT = WIDTH gives STEPS=1: the full-width ripple completes in one RUN cycle.
  - Wrap-around is modulo 2^WIDTH, with cout reporting the lost bit.
  - start held high continuously launches a new operation each time IDLE is re-entered.

Test Plan:
- WIDTH=8, DIGIT=1; a=0x7F, b=0x01, cin=0, sub=0, start one cycle.
  - busy high for 8 cycles, then done pulses once.
  - Result: sum=0x80, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=1, sub=0 → sum=0x01, cout=1, ovf=0.
  - Previous result (0x80/0/1) must hold until this done.
- sub=1: a=0x05, b=0x07, cin=0 → sum=0xFE, cout=0, ovf=0.
- sub=1: a=0x80, b=0x01, cin=0 → sum=0x7F, cout=1, ovf=1.
- WIDTH=16, DIGIT=4; a=0xFFFF, b=0x0001, cin=0.
  - busy for exactly 4 cycles.
  - Result: sum=0x0000, cout=1, ovf=0.
- Control abuse (WIDTH=8, DIGIT=1): start pulses during RUN and during DONE are ignored, and only one done is produced.
  - Then assert rst in RUN step 3: no done follows, and all outputs read 0 on the next cycle.
  - A new start after reset completes normally.
  - Randomised sweep of a, b, cin, sub matches a {cout,sum} reference model.
